uart_tx_fifo: RTL

Parametrised UART transmitter, successor to the fixed 8N1 transmitter in the serial I/O path.
- Configurable data width, parity mode and stop-bit count.
- Built-in write FIFO, so the host can queue several characters without waiting for each frame to finish.
- Queued frames go out back-to-back with no idle gap.

---
 rtl/uart_tx_fifo.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with configurable framing and a write queue.
// Characters are queued in a small FIFO and sent back-to-back; the serial
// line, activity flag and done pulse are all registered.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_L,
  input  logic                          i_Tx_DV,
  input  logic [DATA_BITS-1:0]          i_Tx_Byte,
  output logic                          o_Tx_Ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;

  localparam logic [CNT_W-1:0] LAST_CLK  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
  localparam logic [CW-1:0]    FULL_CNT  = CW'(FIFO_DEPTH);

  // Reject configurations the datapath cannot represent.
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_fifo: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Odd parity makes the total count of ones odd; even makes it even.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  // FIFO storage and control
  logic [DATA_BITS-1:0] r_Mem [FIFO_DEPTH];
  logic [AW-1:0]        r_Wr_Ptr;
  logic [AW-1:0]        r_Rd_Ptr;
  logic [CW-1:0]        r_Count;
  logic                 w_Ready;
  logic                 w_Push;
  logic                 w_Pop;

  // Transmit FSM and datapath
  state_t               r_State;
  state_t               w_State_Next;
  logic [CNT_W-1:0]     r_Clk_Cnt;
  logic [CNT_W-1:0]     w_Clk_Next;
  logic [IDX_W-1:0]     r_Bit_Idx;
  logic [IDX_W-1:0]     w_Bit_Next;
  logic [DATA_BITS-1:0] r_Data;
  logic                 r_Tx_Serial;
  logic                 w_Serial_Next;
  logic                 r_Tx_Active;
  logic                 w_Active_Next;
  logic                 r_Tx_Done;
  logic                 w_Done_Next;
  logic                 w_Bit_End;

  // Ready comes from the registered count, so a full FIFO drops a strobe
  // even when the FSM pops in the same cycle.
  assign w_Ready   = (r_Count < FULL_CNT);
  assign w_Push    = i_Tx_DV & w_Ready;
  assign w_Bit_End = (r_Clk_Cnt == LAST_CLK);

  // FIFO pointers and occupancy count.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      r_Wr_Ptr <= '0;
      r_Rd_Ptr <= '0;
      r_Count  <= '0;
    end else begin
      if (w_Push) r_Wr_Ptr <= r_Wr_Ptr + AW'(1);
      if (w_Pop)  r_Rd_Ptr <= r_Rd_Ptr + AW'(1);
      case ({w_Push, w_Pop})
        2'b10:   r_Count <= r_Count + CW'(1);
        2'b01:   r_Count <= r_Count - CW'(1);
        default: r_Count <= r_Count;
      endcase
    end
  end

  // FIFO storage write and character latch on pop; data needs no reset.
  always_ff @(posedge i_Clock) begin
    if (w_Push) r_Mem[r_Wr_Ptr] <= i_Tx_Byte;
    if (w_Pop)  r_Data <= r_Mem[r_Rd_Ptr];
  end

  // FSM state, counters and registered line outputs.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      r_State     <= S_IDLE;
      r_Clk_Cnt   <= '0;
      r_Bit_Idx   <= '0;
      r_Tx_Serial <= 1'b1;
      r_Tx_Active <= 1'b0;
      r_Tx_Done   <= 1'b0;
    end else begin
      r_State     <= w_State_Next;
      r_Clk_Cnt   <= w_Clk_Next;
      r_Bit_Idx   <= w_Bit_Next;
      r_Tx_Serial <= w_Serial_Next;
      r_Tx_Active <= w_Active_Next;
      r_Tx_Done   <= w_Done_Next;
    end
  end

  // Next-state logic; the line value is derived from the next state so the
  // registered output changes on the same edge as the state.
  always_comb begin
    w_State_Next  = r_State;
    w_Clk_Next    = r_Clk_Cnt;
    w_Bit_Next    = r_Bit_Idx;
    w_Pop         = 1'b0;
    w_Done_Next   = 1'b0;
    w_Serial_Next = 1'b1;
    w_Active_Next = 1'b0;

    case (r_State)
      S_IDLE: begin
        w_Clk_Next = '0;
        w_Bit_Next = '0;
        if (r_Count != '0) begin
          w_Pop        = 1'b1;
          w_State_Next = S_START;
        end
      end
      S_START: begin
        if (w_Bit_End) begin
          w_Clk_Next   = '0;
          w_Bit_Next   = '0;
          w_State_Next = S_DATA;
        end else begin
          w_Clk_Next = r_Clk_Cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (w_Bit_End) begin
          w_Clk_Next = '0;
          if (r_Bit_Idx == LAST_DATA) begin
            w_Bit_Next   = '0;
            w_State_Next = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            w_Bit_Next = r_Bit_Idx + IDX_W'(1);
          end
        end else begin
          w_Clk_Next = r_Clk_Cnt + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (w_Bit_End) begin
          w_Clk_Next   = '0;
          w_Bit_Next   = '0;
          w_State_Next = S_STOP;
        end else begin
          w_Clk_Next = r_Clk_Cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (w_Bit_End) begin
          w_Clk_Next = '0;
          if (r_Bit_Idx == LAST_STOP) begin
            w_Bit_Next  = '0;
            w_Done_Next = 1'b1;
            // Chain straight into the next frame when more data is queued.
            if (r_Count != '0) begin
              w_Pop        = 1'b1;
              w_State_Next = S_START;
            end else begin
              w_State_Next = S_IDLE;
            end
          end else begin
            w_Bit_Next = r_Bit_Idx + IDX_W'(1);
          end
        end else begin
          w_Clk_Next = r_Clk_Cnt + CNT_W'(1);
        end
      end
      default: begin
        w_State_Next = S_IDLE;
        w_Clk_Next   = '0;
        w_Bit_Next   = '0;
      end
    endcase

    case (w_State_Next)
      S_START:  w_Serial_Next = 1'b0;
      S_DATA:   w_Serial_Next = r_Data[w_Bit_Next];
      S_PARITY: w_Serial_Next = parity_bit(r_Data);
      default:  w_Serial_Next = 1'b1;
    endcase
    w_Active_Next = (w_State_Next != S_IDLE);
  end

  assign o_Tx_Ready   = w_Ready;
  assign o_Fifo_Count = r_Count;
  assign o_Tx_Active  = r_Tx_Active;
  assign o_Tx_Serial  = r_Tx_Serial;
  assign o_Tx_Done    = r_Tx_Done;

endmodule
